stopwatch_ctrl: RTL
===================

// Module: stopwatch_ctrl
// PURPOSE
//   Mode controller for the stopwatch time counter. Debounces the raw RUN and LAP keys and
//   sequences the counter through IDLE/RUNNING/PAUSED/LAP. Issues the 100 Hz advance strobe,
//   the clear pulse and the lap-capture pulse, and selects live or lap time for the display
//   path (hex_test -> HC595). The time counter owns no pause logic; it counts on tick_en only.
// PARAMETERS
//   CLOCK_FREQ   50000000  system clock, Hz
//   TICK_FREQ    100       advance-strobe rate, Hz; TICK_CYCLE = CLOCK_FREQ/TICK_FREQ-1
//   DEBOUNCE_MS  20        key stable time; DB_CYCLES = (CLOCK_FREQ/1000)*DEBOUNCE_MS
// PORTS
//   clk       in   1  system clock, all logic on posedge
//   reset     in   1  asynchronous, active-low; clears all state
//   key_run   in   1  raw RUN key, asynchronous, pressed = 0
//   key_lap   in   1  raw LAP key, asynchronous, pressed = 0
//   tick_en   out  1  one-cycle strobe; the time counter advances 0.01 s
//   clr       out  1  one-cycle pulse; the time counter and lap register clear to 0
//   lap_load  out  1  one-cycle pulse; the lap register captures live time
//   disp_sel  out  1  0 = live time to display, 1 = lap register to display
//   state     out  2  00 IDLE, 01 RUNNING, 10 PAUSED, 11 LAP
// BEHAVIOUR
//   Reset (async, immediate, also mid-operation): state=IDLE.
//     tick_en=clr=lap_load=disp_sel=0. Prescaler=0, debounce counters=0.
//     Synchronizer and debounced levels=1 (released).
//   Keys: 2-FF synchronizer, then debounce. Debounced level changes only after DB_CYCLES
//     consecutive equal synced samples. A press event is a 1-cycle pulse on a debounced 1->0 edge.
//     The pulse fires <= DB_CYCLES+4 cycles after the raw edge. A glitch shorter than DB_CYCLES
//     gives no event. Release gives no event. A held key gives exactly one event.
//   Prescaler: 0..TICK_CYCLE, increments only in RUNNING or LAP. It holds its value in PAUSED,
//     so resume keeps the phase. It is cleared to 0 when entering IDLE.
//     At the terminal count it wraps to 0. tick_en is high in the next cycle, for 1 cycle only.
//   FSM (registered; outputs valid in the cycle after the event; run_ev has priority):
//     IDLE    : run_ev -> RUNNING; lap_ev ignored
//     RUNNING : run_ev -> PAUSED; lap_ev -> LAP with lap_load=1 for 1 cycle
//     LAP     : lap_ev -> RUNNING; run_ev -> PAUSED; counting continues
//     PAUSED  : run_ev -> RUNNING; lap_ev -> IDLE with clr=1 for 1 cycle
//   Simultaneous run_ev and lap_ev: run_ev is applied, lap_ev is dropped (no lap_load, no clr).
//   disp_sel=1 only in LAP. It returns to 0 on the same edge the state leaves LAP.
//   A tick already pending when pausing is still issued. No further ticks occur until resume.
//   clr and lap_load are never high together. tick_en is never high in IDLE except a pending tick
//     (impossible: IDLE is reached only from PAUSED).
// TESTING  (bench params: CLOCK_FREQ=1000, TICK_FREQ=100 -> TICK_CYCLE=9, DEBOUNCE_MS=2 -> DB_CYCLES=2)
//   1 Release reset, keys idle 200 cycles -> state=00, all outputs 0 throughout.
//   2 key_run=0 for 20 cycles, then 1 -> one transition to 01. tick_en pulses every 10 cycles,
//     21 pulses in 210 cycles.
//   3 In RUNNING, key_run=0 for 1 cycle -> no state change, tick period stays 10.
//   4 RUNNING, press LAP -> lap_load one pulse, state 11, disp_sel 1, ticks continue.
//     Press LAP again -> state 01, disp_sel 0, no lap_load.
//   5 Pause with prescaler=4 -> state 10, no ticks for 100 cycles. Resume -> first tick after
//     exactly 6 counting cycles. Pause, press LAP -> clr one pulse, state 00.
//   6 RUNNING, RUN and LAP pressed in the same cycle -> state 10, lap_load stays 0.
//     In LAP, assert reset mid-period -> state 00 and all outputs 0 without waiting for clk.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode controller: debounces RUN/LAP keys, sequences IDLE/RUNNING/PAUSED/LAP,
// and issues the 100 Hz advance strobe plus the clear and lap-capture pulses.
module stopwatch_ctrl #(
    parameter int CLOCK_FREQ  = 50000000,
    parameter int TICK_FREQ   = 100,
    parameter int DEBOUNCE_MS = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_run,
    input  logic       key_lap,
    output logic       tick_en,
    output logic       clr,
    output logic       lap_load,
    output logic       disp_sel,
    output logic [1:0] state
);

    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] RUNNING = 2'b01;
    localparam logic [1:0] PAUSED  = 2'b10;
    localparam logic [1:0] LAP     = 2'b11;

    localparam int TICK_CYCLE = CLOCK_FREQ / TICK_FREQ - 1;
    localparam int PW         = (TICK_CYCLE > 0) ? $clog2(TICK_CYCLE + 1) : 1;
    localparam int DB_CYCLES  = (CLOCK_FREQ / 1000) * DEBOUNCE_MS;
    localparam int DBW        = (DB_CYCLES > 0) ? $clog2(DB_CYCLES + 1) : 1;

    logic [1:0]    key_raw;
    logic [1:0]    key_ev;
    logic          run_ev;
    logic          lap_ev;
    logic [1:0]    next_state;
    logic          next_lap_load;
    logic          next_clr;
    logic          counting;
    logic [PW-1:0] presc;

    assign key_raw = {key_lap, key_run};

    // Index 0 is RUN, index 1 is LAP; keys idle high, so every stage resets to 1.
    for (genvar i = 0; i < 2; i++) begin : g_key
        logic           sync_a;
        logic           sync_b;
        logic           level;
        logic           level_d;
        logic [DBW-1:0] cnt;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sync_a  <= 1'b1;
                sync_b  <= 1'b1;
                level   <= 1'b1;
                level_d <= 1'b1;
                cnt     <= '0;
            end else begin
                sync_a  <= key_raw[i];
                sync_b  <= sync_a;
                level_d <= level;
                if (sync_b == level) begin
                    cnt <= '0;
                end else if (cnt == DBW'(DB_CYCLES - 1)) begin
                    level <= sync_b;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + DBW'(1);
                end
            end
        end

        assign key_ev[i] = level_d & ~level;
    end

    assign run_ev   = key_ev[0];
    assign lap_ev   = key_ev[1];
    assign counting = (state == RUNNING) || (state == LAP);

    // RUN always wins; a LAP event arriving in the same cycle is simply discarded.
    always_comb begin
        next_state    = state;
        next_lap_load = 1'b0;
        next_clr      = 1'b0;
        case (state)
            IDLE: begin
                if (run_ev) begin
                    next_state = RUNNING;
                end
            end
            RUNNING: begin
                if (run_ev) begin
                    next_state = PAUSED;
                end else if (lap_ev) begin
                    next_state    = LAP;
                    next_lap_load = 1'b1;
                end
            end
            LAP: begin
                if (run_ev) begin
                    next_state = PAUSED;
                end else if (lap_ev) begin
                    next_state = RUNNING;
                end
            end
            PAUSED: begin
                if (run_ev) begin
                    next_state = RUNNING;
                end else if (lap_ev) begin
                    next_state = IDLE;
                    next_clr   = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            lap_load <= 1'b0;
            clr      <= 1'b0;
            disp_sel <= 1'b0;
        end else begin
            state    <= next_state;
            lap_load <= next_lap_load;
            clr      <= next_clr;
            disp_sel <= (next_state == LAP);
        end
    end

    // The prescaler freezes while paused so a resume keeps the sub-tick phase;
    // a wrap decided on the pausing edge still produces its tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc   <= '0;
            tick_en <= 1'b0;
        end else if (counting) begin
            if (presc == PW'(TICK_CYCLE)) begin
                presc   <= '0;
                tick_en <= 1'b1;
            end else begin
                presc   <= presc + PW'(1);
                tick_en <= 1'b0;
            end
        end else begin
            tick_en <= 1'b0;
            if (next_state == IDLE) begin
                presc <= '0;
            end
        end
    end

endmodule
